// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- constants shared by the alu_pipe block.
//   DEFAULT_WIDTH : default operand/result width
//   alu_op_e      : 2-bit opcode (invert, add, subtract, double)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_INV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_DBL = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_pipe_if -- handshake bundle for alu_pipe.
//   Request side : in_valid, in_ready, A, B, S
//   Result side  : out_valid, out_ready, Y, C, Z, V
//   master : the producer/consumer environment
//   slave  : the ALU pipeline
// ---------------------------------------------------------------------------
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       S;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             C;
  logic             Z;
  logic             V;

  modport master (
    output in_valid, A, B, S, out_ready,
    input  in_ready, out_valid, Y, C, Z, V
  );

  modport slave (
    input  in_valid, A, B, S, out_ready,
    output in_ready, out_valid, Y, C, Z, V
  );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core -- purely combinational ALU datapath.
//   A, B : operands (WIDTH bits)     S : opcode (alu_op_e)
//   Y    : result                    C : carry / borrow / shifted-out bit
//   Z    : Y is all zeros            V : signed overflow
// Optional feature: macro ALU_SAT_EN makes add/double clamp to all ones on
// carry and subtract clamp to zero on borrow; C and V stay raw.
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             Z,
  output logic             V
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] y_final;

  always_comb begin
    raw     = '0;
    V       = 1'b0;
    case (S)
      OP_INV: begin
        raw = {1'b0, ~A};
      end
      OP_ADD: begin
        raw = {1'b0, A} + {1'b0, B};
        V   = (A[WIDTH-1] == B[WIDTH-1]) && (raw[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // Extended two's-complement subtract: bit WIDTH ends up as the borrow.
        raw = {1'b0, A} + ~{1'b0, B} + ONE;
        V   = (A[WIDTH-1] != B[WIDTH-1]) && (raw[WIDTH-1] != A[WIDTH-1]);
      end
      OP_DBL: begin
        raw = {A, 1'b0};
        V   = A[WIDTH-1] ^ A[WIDTH-2];
      end
      default: ;
    endcase
    C       = raw[WIDTH];
    y_final = raw[WIDTH-1:0];
`ifdef ALU_SAT_EN
    // Invert never sets C, so only the three arithmetic ops can clamp.
    if (raw[WIDTH]) begin
      y_final = (S == OP_SUB) ? '0 : '1;
    end
`endif
    Y = y_final;
    Z = ~|y_final;
  end

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes.
//   clk : clock            rst : synchronous active-high reset
//   bus : alu_pipe_if.slave (in_valid/in_ready/A/B/S in,
//                            out_valid/out_ready/Y/C/Z/V out)
// Stage 1 registers the operands, alu_core computes between stages, and
// stage 2 registers the result. Both stages move together whenever the
// output register is empty or being drained, so in_ready is that condition.
// Optional feature: macro ALU_SAT_EN (saturating arithmetic, in alu_core).
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [1:0]       s1_s_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] y_reg;
  logic             c_reg;
  logic             z_reg;
  logic             v_reg;

  logic [WIDTH-1:0] core_y;
  logic             core_c;
  logic             core_z;
  logic             core_v;
  logic             advance;

  assign advance      = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = advance;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .A (s1_a_reg),
    .B (s1_b_reg),
    .S (s1_s_reg),
    .Y (core_y),
    .C (core_c),
    .Z (core_z),
    .V (core_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_s_reg      <= '0;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      c_reg         <= 1'b0;
      z_reg         <= 1'b0;
      v_reg         <= 1'b0;
    end else if (advance) begin
      // Bubbles travel through like data; payload only reloads on valid.
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_reg <= bus.A;
        s1_b_reg <= bus.B;
        s1_s_reg <= bus.S;
      end
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        y_reg <= core_y;
        c_reg <= core_c;
        z_reg <= core_z;
        v_reg <= core_v;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.Y         = y_reg;
  assign bus.C         = c_reg;
  assign bus.Z         = z_reg;
  assign bus.V         = v_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- scoreboard bench for alu_pipe at WIDTH=4.
// Inputs change on the falling edge; handshakes are sampled 1 ns before the
// rising edge. The driver pushes an expected result on every acceptance, a
// separate monitor pops and compares on every output transfer.
// Honours ALU_SAT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int    W   = 4;
  localparam longint MOD = longint'(1) << W;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    logic         v;
    int           acc;
    bit           chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_out = 0;
  exp_t scb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int y, input bit c, input bit z, input bit v);
    exp_t e;
    e.y = y[W-1:0]; e.c = c; e.z = z; e.v = v; e.acc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
    longint ua, ub, sa, sb, r, sr;
    longint hi, lo;
    bit     c, v;
    exp_t   e;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= MOD / 2) ? ua - MOD : ua;
    sb = (ub >= MOD / 2) ? ub - MOD : ub;
    hi = MOD / 2 - 1;
    lo = -(MOD / 2);
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (s)
      2'd0: r = MOD - 1 - ua;
      2'd1: begin
        r = ua + ub; c = (r >= MOD); sr = sa + sb; v = (sr > hi) || (sr < lo);
`ifdef ALU_SAT_EN
        if (c) r = MOD - 1;
`endif
      end
      2'd2: begin
        r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > hi) || (sr < lo);
        if (r < 0) r = r + MOD;
`ifdef ALU_SAT_EN
        if (c) r = 0;
`endif
      end
      default: begin
        r = 2 * ua; c = (r >= MOD); sr = 2 * sa; v = (sr > hi) || (sr < lo);
`ifdef ALU_SAT_EN
        if (c) r = MOD - 1;
`endif
      end
    endcase
    r = r % MOD;
    e = mk(int'(r), c, (r == 0), v);
    return e;
  endfunction

  // One driven cycle; reports whether the DUT accepted the operand set.
  task automatic drive(input bit vld, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] s, input bit ordy, input exp_t e, input bit lat,
                       output bit acc);
    exp_t q;
    @(negedge clk);
    bus.in_valid  = vld;
    bus.A         = a;
    bus.B         = b;
    bus.S         = s;
    bus.out_ready = ordy;
    #4;
    acc = vld && bus.in_ready && !rst;
    if (acc) begin
      q = e; q.acc = cyc; q.chk_lat = lat;
      scb.push_back(q);
    end
  endtask

  // Keeps offering one operand set until taken (bounded).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                       input exp_t e, input bit lat);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) drive(1'b1, a, b, s, 1'b1, e, lat, acc);
    if (!acc) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scb.size() == 0) break;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    chk("drain_empty", 64'(scb.size()), 64'd0);
  endtask

  // Monitor: compares every output transfer against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_out++;
        if (scb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got Y=%0d with nothing expected", bus.Y);
        end else begin
          e = scb.pop_front();
          $display("out %0d: Y=%0d C=%0b Z=%0b V=%0b exp Y=%0d C=%0b Z=%0b V=%0b",
                   n_out, bus.Y, bus.C, bus.Z, bus.V, e.y, e.c, e.z, e.v);
          chk("result", 64'({bus.Y, bus.C, bus.Z, bus.V}), 64'({e.y, e.c, e.z, e.v}));
          if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t         e;
    exp_t         bp_exp[4];
    logic [W-1:0] bp_a[4], bp_b[4];
    logic [1:0]   bp_s[4];
    logic [W-1:0] ra, rb;
    logic [1:0]   rs;
    bit           acc;
    int           k;

    // Reset with an operand offered: must not be accepted.
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.A = 4'd5; bus.B = 4'd1; bus.S = 2'b01; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #4;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_y", 64'(bus.Y), 64'd0);
    chk("rst_czv", 64'({bus.C, bus.Z, bus.V}), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vectors with hand-derived results, unstalled (latency checked).
    issue(4'd3, 4'd0, 2'b00, mk(12, 0, 0, 0), 1'b1);
`ifdef ALU_SAT_EN
    issue(4'd9, 4'd8, 2'b01, mk(15, 1, 0, 1), 1'b1);
    issue(4'd10, 4'd11, 2'b10, mk(0, 1, 1, 0), 1'b1);
    issue(4'd7, 4'd0, 2'b11, mk(14, 0, 0, 1), 1'b1);
    issue(4'd12, 4'd0, 2'b11, mk(15, 1, 0, 0), 1'b1);
`else
    issue(4'd9, 4'd8, 2'b01, mk(1, 1, 0, 1), 1'b1);
    issue(4'd10, 4'd11, 2'b10, mk(15, 1, 0, 0), 1'b1);
    issue(4'd7, 4'd0, 2'b11, mk(14, 0, 0, 1), 1'b1);
    issue(4'd12, 4'd0, 2'b11, mk(8, 1, 0, 0), 1'b1);
`endif
    issue(4'd0, 4'd0, 2'b01, mk(0, 0, 1, 0), 1'b1);
    drain();

    // Backpressure: four distinct ops with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = W'(i + 2); bp_b[i] = W'(3 * i + 1); bp_s[i] = 2'(i);
      bp_exp[i] = model(bp_a[i], bp_b[i], bp_s[i]);
    end
    k = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, bp_a[k], bp_b[k], bp_s[k], 1'b0, bp_exp[k], 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bp_a[k], bp_b[k], bp_s[k], 1'b0, bp_exp[k], 1'b0, acc);
      if (acc) k++;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_y_stable", 64'(bus.Y), 64'(bp_exp[0].y));
    end
    for (int i = 0; i < 20 && k < 4; i++) begin
      drive(1'b1, bp_a[k], bp_b[k], bp_s[k], 1'b1, bp_exp[k], 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_all_issued", 64'(k), 64'd4);
    drain();

    // Reset while results are in flight.
    for (int i = 0; i < 3; i++) issue(W'(i + 5), W'(i), 2'b01, model(W'(i + 5), W'(i), 2'b01), 1'b0);
    @(negedge clk);
    chk("rstmid_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.A = 4'd6; bus.S = 2'b11;
    #4;
    scb.delete();
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #4;
    chk("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstmid_y", 64'(bus.Y), 64'd0);
    chk("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (8) @(negedge clk);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom_range(0, int'(MOD) - 1));
      rb = W'($urandom_range(0, int'(MOD) - 1));
      rs = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, ra, rb, rs, $urandom_range(0, 3) != 0,
            model(ra, rb, rs), 1'b0, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal values 2 to 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set on A/B/S is presented.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 B  input  WIDTH  operand B.
REQ-008 S  input  2  opcode: 00 invert A, 01 A+B, 10 A-B, 11 double A.
REQ-009 out_valid  output  1  Y/C/Z/V hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 Y  output  WIDTH  result.
REQ-012 C  output  1  carry (add), borrow (sub), bit shifted out (double), 0 (invert).
REQ-013 Z  output  1  1 when Y is all zeros.
REQ-014 V  output  1  signed overflow for add/sub/double; 0 for invert.

Function
REQ-015 Transfer in: when in_valid and in_ready are both high at a clock edge; out: when out_valid and out_ready are both high.
REQ-016 Two register stages: stage 1 captures A, B, S; stage 2 captures Y, C, Z, V computed from stage 1.
REQ-017 Latency: result appears with out_valid=1 exactly 2 cycles after acceptance when not stalled.
REQ-018 Pipeline advance = !out_valid || out_ready; in_ready equals advance; both stages hold when advance is 0.
REQ-019 Stalled stages keep A, B, S, Y, C, Z, V stable; bubbles are not collapsed during a stall.
REQ-020 Results leave in acceptance order; no operand set is dropped or duplicated.
REQ-021 Throughput: one operation per cycle while out_ready stays high.
REQ-022 Arithmetic: computed at WIDTH+1 bits; C is bit WIDTH of the result; subtraction is A + ~B + 1 with C = borrow (A < B unsigned).
REQ-023 V: add sets V when A and B have the same sign and Y's sign differs. Sub sets V when A and B differ in sign and Y's sign differs from A. Double sets V when A[WIDTH-1] != A[WIDTH-2].
REQ-024 Default wrap-around: Y equals the result modulo 2^WIDTH.
REQ-025 Z is computed from the final Y, after saturation where that applies.
REQ-026 Acceptance and output transfer in the same cycle are legal and do not stall.

Reset
REQ-027 While rst is high at an edge, both stage valids, out_valid, Y, C, Z and V become 0.
REQ-028 Reset mid-operation discards all in-flight operations; in_ready is 1 the cycle after reset releases.
REQ-029 Operands offered while rst is high are not accepted.

Configuration
REQ-030 Macro ALU_SAT_EN: when defined, the operations saturate instead of wrapping.
- Add with C=1 gives Y all ones.
- Sub with borrow gives Y=0.
- Double with C=1 gives Y all ones.
- C and V still report the raw, unsaturated condition.
REQ-031 Without ALU_SAT_EN, the behaviour of REQ-024 applies and no saturation logic is built.

Structure
REQ-032 Shared package alu_pkg holds the opcode constants OP_INV=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_DBL=2'b11 and the default WIDTH constant.
REQ-033 One combinational sub-module, alu_core: inputs A, B, S; outputs Y, C, Z, V; instantiated between stage 1 and stage 2.

Verification (WIDTH=4)
REQ-034 Invert: S=00, A=3 -> Y=12, C=0, Z=0, V=0, two cycles after acceptance.
REQ-035 Add: S=01, A=9, B=8 -> C=1, V=1. Without ALU_SAT_EN, Y=1. With ALU_SAT_EN, Y=15.
REQ-036 Sub: S=10, A=10, B=11 -> C=1, V=0. Without ALU_SAT_EN, Y=15. With ALU_SAT_EN, Y=0 and Z=1.
REQ-037 Double: S=11, A=7 -> Y=14, C=0, V=1. Also S=11, A=12 -> C=1; Y=8 without ALU_SAT_EN, Y=15 with it.
REQ-038 Backpressure: issue 4 ops back-to-back and hold out_ready=0 -> in_ready=0 and Y stable once both stages are full. Then raise out_ready -> all 4 results emerge in order with no loss.
REQ-039 Reset mid-op: rst=1 for one cycle while out_valid=1 -> next cycle out_valid=0, Y=0, in_ready=1, and no stale result appears afterwards.
